// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the mod_counter slice.
// Optional prescaler feature is selected by MOD_COUNTER_PRESCALER_EN.
package mod_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2w(input int n);
    int w;
    for (w = 1; (1 << w) < n; w++) begin
    end
    return w;
  endfunction

endpackage

// File: rtl/mod_counter_if.sv
// Control/status bundle between a sequencer (master) and mod_counter (slave).
interface mod_counter_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             up_dn;
  logic             oneshot;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             wrap;
  logic             done;

  modport master (
    output en, up_dn, oneshot, load, load_val,
    input  cnt, tc, wrap, done
  );

  modport slave (
    input  en, up_dn, oneshot, load, load_val,
    output cnt, tc, wrap, done
  );
endinterface

// File: rtl/mod_counter_tick_prescaler.sv
// Divides en into one tick every PRESCALE enabled cycles; en low freezes it.
// Only instantiated when MOD_COUNTER_PRESCALER_EN is defined.
module tick_prescaler
  import mod_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);
  localparam int            PW   = clog2w(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pc;

  assign o_tick = i_en && (r_pc == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr)  r_pc <= '0;
    else if (o_tick)     r_pc <= '0;
    else if (i_en)       r_pc <= r_pc + 1'b1;
  end
endmodule

// File: rtl/mod_counter.sv
// Modulo-MX up/down counter with load, wrap/one-shot modes and tc/wrap/done flags.
// Define MOD_COUNTER_PRESCALER_EN to divide en by PRESCALE before it counts.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MX       = 4,
  parameter int PRESCALE = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  mod_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MX - 1);

  logic [WIDTH-1:0] r_cnt;
  logic             r_wrap;
  logic             r_done;
  logic             w_tick;
  logic             w_tc;
  logic             w_up;
  logic [WIDTH-1:0] w_load_cl;

  // Illegal parameter combinations leave a named marker in the hierarchy.
  if (MX < 1 || PRESCALE < 1) begin : g_bad_params
  end

`ifdef MOD_COUNTER_PRESCALER_EN
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (bus.load),
    .i_en   (bus.en),
    .o_tick (w_tick)
  );
`else
  assign w_tick = bus.en;
`endif

  assign w_up      = (bus.up_dn == DIR_UP);
  assign w_tc      = w_up ? (r_cnt == TOP) : (r_cnt == '0);
  assign w_load_cl = (bus.load_val > TOP) ? TOP : bus.load_val;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
      r_done <= 1'b0;
    end else if (bus.load) begin
      r_cnt  <= w_load_cl;
      r_wrap <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_tick && !r_done) begin
        if (w_tc) begin
          r_wrap <= 1'b1;
          // One-shot parks on the terminal value instead of wrapping.
          if (bus.oneshot == MODE_ONESHOT) r_done <= 1'b1;
          else                             r_cnt  <= w_up ? '0 : TOP;
        end else begin
          r_cnt <= w_up ? r_cnt + 1'b1 : r_cnt - 1'b1;
        end
      end
    end
  end

  assign bus.cnt  = r_cnt;
  assign bus.tc   = w_tc;
  assign bus.wrap = r_wrap;
  assign bus.done = r_done;
endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter (WIDTH=8, MX=5, plus an MX=1 instance).
// Builds with or without MOD_COUNTER_PRESCALER_EN (PRESCALE=3 when defined).
module tb_mod_counter;
`ifdef MOD_COUNTER_PRESCALER_EN
  localparam int PS = 3;
`else
  localparam int PS = 1;
`endif
  localparam int MX = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  mod_counter_if #(.WIDTH(8)) bif ();
  mod_counter_if #(.WIDTH(8)) bif1 ();

  mod_counter #(.WIDTH(8), .MX(MX), .PRESCALE(PS)) u_dut (
    .i_clk (clk), .i_rst (rst), .bus (bif)
  );

  mod_counter #(.WIDTH(8), .MX(1), .PRESCALE(PS)) u_dut1 (
    .i_clk (clk), .i_rst (rst), .bus (bif1)
  );

  assign bif1.en       = bif.en;
  assign bif1.up_dn    = bif.up_dn;
  assign bif1.oneshot  = bif.oneshot;
  assign bif1.load     = bif.load;
  assign bif1.load_val = bif.load_val;

  int e1 [12] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};
  int e2 [5]  = '{2, 1, 0, 4, 3};
  int e3 [5]  = '{3, 4, 4, 4, 4};

  // {en, up_dn, oneshot, load, load_val} vectors checked only through the model.
  logic [11:0] vec [12] = '{
    {1'b1, 1'b0, 1'b0, 1'b0, 8'd0},  {1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
    {1'b0, 1'b1, 1'b0, 1'b0, 8'd0},  {1'b1, 1'b1, 1'b1, 1'b0, 8'd0},
    {1'b1, 1'b1, 1'b1, 1'b0, 8'd0},  {1'b1, 1'b0, 1'b1, 1'b1, 8'd200},
    {1'b1, 1'b0, 1'b1, 1'b0, 8'd0},  {1'b1, 1'b1, 1'b1, 1'b0, 8'd0},
    {1'b1, 1'b1, 1'b0, 1'b1, 8'd4},  {1'b1, 1'b1, 1'b0, 1'b0, 8'd0},
    {1'b1, 1'b0, 1'b0, 1'b0, 8'd0},  {1'b1, 1'b0, 1'b1, 1'b0, 8'd0}
  };

  // Reference model: value kept as a plain integer in 0..MX-1.
  int m_cnt = 0, m_ps = 0;
  bit m_wrap = 1'b0, m_done = 1'b0;

  always @(posedge clk) begin : model
    int nxt;
    bit tick;
    if (rst) begin
      m_cnt = 0; m_ps = 0; m_wrap = 0; m_done = 0;
    end else if (bif.load) begin
      m_cnt  = (bif.load_val > MX - 1) ? MX - 1 : int'(bif.load_val);
      m_ps   = 0; m_wrap = 0; m_done = 0;
    end else begin
      tick = 0;
      if (bif.en) begin
        if (m_ps == PS - 1) begin tick = 1; m_ps = 0; end
        else m_ps++;
      end
      m_wrap = 0;
      if (tick && !m_done) begin
        nxt = bif.up_dn ? m_cnt + 1 : m_cnt - 1;
        if (nxt < 0 || nxt >= MX) begin
          m_wrap = 1;
          if (bif.oneshot) m_done = 1;
          else             m_cnt  = (nxt + MX) % MX;
        end else begin
          m_cnt = nxt;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_cnt",  bif.cnt,  m_cnt);
      check("model_wrap", bif.wrap, m_wrap);
      check("model_done", bif.done, m_done);
      check("model_tc",   bif.tc,   bif.up_dn ? (m_cnt == MX - 1) : (m_cnt == 0));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    bif.en = 0; bif.up_dn = 1; bif.oneshot = 0; bif.load = 0; bif.load_val = '0;
    cyc();
    chk_on = 1'b1;
    check("rst_cnt",  bif.cnt,  0);
    check("rst_wrap", bif.wrap, 0);
    check("rst_done", bif.done, 0);
    check("rst_tc_up", bif.tc, 0);
    check("mx1_cnt", bif1.cnt, 0);
    check("mx1_tc",  bif1.tc,  1);
    bif.up_dn = 0; #1;
    check("rst_tc_dn", bif.tc, 1);
    bif.up_dn = 1;

`ifndef MOD_COUNTER_PRESCALER_EN
    cyc(); rst = 0; bif.en = 1;
    for (int i = 0; i < 12; i++) begin
      check("t1_cnt",   bif.cnt,   e1[i]);
      check("t1_wrap",  bif.wrap,  (i == 5 || i == 10));
      check("mx1_wrap", bif1.wrap, (i > 0));
      cyc();
    end

    bif.en = 0; bif.up_dn = 0; bif.load_val = 8'd2; bif.load = 1;
    cyc(); bif.load = 0; bif.en = 1;
    for (int i = 0; i < 5; i++) begin
      check("t2_cnt",  bif.cnt,  e2[i]);
      check("t2_tc",   bif.tc,   (e2[i] == 0));
      check("t2_wrap", bif.wrap, (i == 3));
      cyc();
    end

    bif.en = 0; bif.up_dn = 1; bif.oneshot = 1; bif.load_val = 8'd3; bif.load = 1;
    cyc(); bif.load = 0; bif.en = 1;
    for (int i = 0; i < 5; i++) begin
      check("t3_cnt",  bif.cnt,  e3[i]);
      check("t3_wrap", bif.wrap, (i == 2));
      check("t3_done", bif.done, (i >= 2));
      cyc();
    end
    bif.oneshot = 0;
    cyc();
    check("t3_sticky_done", bif.done, 1);
    check("t3_sticky_cnt",  bif.cnt,  4);
    bif.load_val = 8'd0; bif.load = 1;
    cyc();
    check("t3_clr_done", bif.done, 0);
    check("t3_clr_cnt",  bif.cnt,  0);
    bif.load = 0;
    cyc();
    check("t3_resume", bif.cnt, 1);
`else
    cyc(); rst = 0; bif.en = 1;
    for (int i = 0; i < 8; i++) begin
      check("ps_cnt", bif.cnt, i / 3);
      cyc();
    end
    bif.en = 0;
    cyc(); cyc();
    check("ps_frozen", bif.cnt, 2);
    bif.en = 1;
    cyc();
    check("ps_resume", bif.cnt, 3);
`endif

    bif.en = 0; bif.load_val = 8'd9; bif.load = 1;
    cyc();
    check("t4_clamp", bif.cnt, 4);
    bif.load_val = 8'd1; bif.en = 1; bif.up_dn = 1;
    cyc();
    check("t4_load_wins", bif.cnt, 1);
    cyc();
    check("t4_load_hold", bif.cnt, 1);
    check("t4_load_wrap", bif.wrap, 0);
    rst = 1; bif.load_val = 8'd3;
    cyc();
    check("t4_rst_wins", bif.cnt, 0);
    rst = 0; bif.load = 0; bif.en = 0;

`ifndef MOD_COUNTER_PRESCALER_EN
    bif.en = 1; bif.oneshot = 0;
    cyc(); cyc(); cyc();
    check("t5_pre_cnt",  bif.cnt,  3);
    check("t5_pre_done", bif.done, 0);
    rst = 1;
    cyc();
    rst = 0;
    check("t5_rst_cnt",  bif.cnt,  0);
    check("t5_rst_wrap", bif.wrap, 0);
    check("t5_rst_done", bif.done, 0);
    cyc();
    check("t5_restart1", bif.cnt, 1);
    cyc();
    check("t5_restart2", bif.cnt, 2);
`endif

    for (int i = 0; i < 12; i++) begin
      {bif.en, bif.up_dn, bif.oneshot, bif.load, bif.load_val} = vec[i];
      cyc();
    end
    bif.en = 1; bif.load = 0; bif.oneshot = 0;
    for (int i = 0; i < 20; i++) cyc();

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo counter, successor to the fixed up-only wrap counter. Counts 0..MX-1 up or down with clock enable, synchronous parallel load, wrap or one-shot mode, and terminal-count/wrap flags. Used as the generic sequencing and timebase counter feeding FSMs and display/scan logic in the lab designs.

## Interface
- WIDTH, 32: counter width in bits; must satisfy MX-1 < 2^WIDTH.
- MX, 4: modulus; counter spans 0..MX-1; MX >= 1.
- PRESCALE, 1: tick divider, used only when the configuration macro is defined; PRESCALE >= 1.

- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  count enable; a tick is generated only while high.
- up_dn  in  1  direction: 1 = up, 0 = down.
- oneshot  in  1  mode: 0 = wrap (free-run), 1 = one-shot (stop at terminal).
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  load value.
- cnt  out  WIDTH  current count, registered.
- tc  out  1  combinational: cnt equals the terminal value for the current up_dn (MX-1 up, 0 down).
- wrap  out  1  registered one-cycle pulse: a tick was taken at terminal count.
- done  out  1  registered sticky flag: one-shot run has finished.

## Operation
- Priority per cycle: rst > load > tick > hold.
- rst: cnt=0, wrap=0, done=0, prescaler cleared; applies mid-run, mid-load, mid-prescale.
- load: cnt = (load_val > MX-1) ? MX-1 : load_val (clamped); done=0; wrap=0; prescaler cleared; any coincident tick discarded.
- tick (en high, and prescaler terminal when enabled), done low:
  - not at terminal: cnt = cnt+1 (up) or cnt-1 (down); wrap=0.
  - at terminal, wrap mode: cnt = 0 (up) or MX-1 (down); wrap=1.
  - at terminal, one-shot mode: cnt holds; wrap=1; done=1.
- While done high: ticks ignored, cnt holds, wrap=0; cleared only by load or rst. Clearing oneshot does not clear done.
- No tick: cnt holds, wrap=0.
- up_dn/oneshot changes take effect on the next tick; tc follows up_dn immediately (same cycle).
- MX=1: cnt stays 0; tc always 1; every tick pulses wrap (and sets done in one-shot).
- Arithmetic in WIDTH bits; cnt never leaves 0..MX-1, so no native WIDTH overflow/underflow is ever produced.

## Timing
- Reset values: cnt=0, wrap=0, done=0; tc=1 after reset if up_dn=0 (or MX=1), else 0.
- Tick at edge N -> new cnt and wrap visible after edge N; latency 1 cycle.
- wrap is high for exactly one cycle per terminal tick; continuous en in wrap mode gives wrap once per MX ticks.
- Load latency 1 cycle; load held high holds cnt at the clamped value.
- With prescaler: first tick occurs PRESCALE cycles of en after reset/load; en low freezes the prescaler without clearing it.

## Configuration
- MOD_COUNTER_PRESCALER_EN defined: internal prescaler counts 0..PRESCALE-1 on en; tick = en && prescaler at PRESCALE-1; prescaler wraps on that tick. PRESCALE=1 is identical to the disabled case.
- Undefined: tick = en; PRESCALE ignored; no prescaler logic instantiated.

## Structure
- Shared package mod_counter_pkg: DIR_UP=1, DIR_DOWN=0, MODE_WRAP=0, MODE_ONESHOT=1 constants and a clog2-style width helper.
- One sub-module: tick_prescaler (clk, rst, clr, en -> tick), instantiated only under MOD_COUNTER_PRESCALER_EN.

## Test plan
- WIDTH=8, MX=5, up, wrap, en=1 for 12 cycles after rst -> cnt 0,1,2,3,4,0,1,2,3,4,0,1; wrap high exactly on cycles where cnt goes 4->0.
- Down, wrap, load_val=2 then en=1 -> cnt 2,1,0,4,3; tc high while cnt=0; wrap on 0->4.
- Up, one-shot, load 3, en=1 for 5 cycles -> cnt 3,4,4,4,4; wrap one pulse; done=1 sticky; load 0 clears done, counting resumes.
- load_val=9 with MX=5 -> cnt=4; load and en same cycle -> load wins, cnt=load value; rst asserted with load -> cnt=0.
- Reset mid-run: cnt=3, done=0, rst for 1 cycle -> cnt=0, wrap=0, done=0 next cycle, counting restarts from 0.
- With MOD_COUNTER_PRESCALER_EN, PRESCALE=3, MX=5, en=1 -> cnt increments every 3rd cycle; en low for 2 cycles mid-prescale delays next increment by exactly 2 cycles.
